// File: rtl/regfile_write_scheduler.sv
// Owns the register-file write port: sequenced post-reset clear, then WB-priority
// arbitration against a debug/loader requester with starvation-driven pipeline stall.
module regfile_write_scheduler #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_we,
  input  logic [$clog2(NREG)-1:0] wb_rd,
  input  logic [XLEN-1:0]         wb_data,
  input  logic                    dbg_valid,
  input  logic [$clog2(NREG)-1:0] dbg_rd,
  input  logic [XLEN-1:0]         dbg_data,
  output logic                    dbg_ready,
  input  logic                    clr_req,
  output logic                    rf_we,
  output logic [$clog2(NREG)-1:0] rf_rd,
  output logic [XLEN-1:0]         rf_wdata,
  output logic                    init_busy,
  output logic                    dbg_stall,
  output logic                    wb_conflict
);

  localparam int IW = $clog2(NREG);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state;
  logic [IW-1:0] clr_idx;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_nxt;
  logic          wb_eff;
  logic          in_clear;
  logic          in_run;

  // Gating with rst keeps every output at 0 for as long as reset is held.
  assign in_clear = rst && (state == CLEAR);
  assign in_run   = rst && (state == RUN);
  assign wb_eff   = wb_we && (wb_rd != '0);
  assign wait_nxt = (wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + WW'(1);

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    rf_we     = 1'b0;
    rf_rd     = '0;
    rf_wdata  = '0;
    dbg_ready = 1'b0;
    init_busy = 1'b0;
    if (in_clear) begin
      init_busy = 1'b1;
      rf_we     = 1'b1;
      rf_rd     = clr_idx;
    end else if (in_run) begin
      if (wb_eff) begin
        rf_we    = 1'b1;
        rf_rd    = wb_rd;
        rf_wdata = wb_data;
      end else begin
        dbg_ready = 1'b1;
        if (dbg_valid && (dbg_rd != '0)) begin
          rf_we    = 1'b1;
          rf_rd    = dbg_rd;
          rf_wdata = dbg_data;
        end
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= CLEAR;
      clr_idx     <= IW'(1);
      wait_cnt    <= '0;
      dbg_stall   <= 1'b0;
      wb_conflict <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          wb_conflict <= wb_we;
          wait_cnt    <= '0;
          dbg_stall   <= 1'b0;
          clr_idx     <= clr_idx + IW'(1);
          if (clr_idx == IW'(NREG - 1)) state <= RUN;
        end
        RUN: begin
          wb_conflict <= 1'b0;
          if (clr_req) begin
            state     <= CLEAR;
            clr_idx   <= IW'(1);
            wait_cnt  <= '0;
            dbg_stall <= 1'b0;
          end else if (dbg_valid && !dbg_ready) begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == WW'(MAX_WAIT)) dbg_stall <= 1'b1;
          end else begin
            // Handshake or withdrawal both end the wait.
            wait_cnt  <= '0;
            dbg_stall <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: clear sequence, arbitration,
// starvation stall, re-clear with discarded WB, and asynchronous reset mid-clear.
module tb_regfile_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        dbg_valid;
  logic [4:0]  dbg_rd;
  logic [31:0] dbg_data;
  logic        dbg_ready;
  logic        clr_req;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        init_busy;
  logic        dbg_stall;
  logic        wb_conflict;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_write_scheduler #(.XLEN(32), .NREG(32), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_valid(dbg_valid), .dbg_rd(dbg_rd), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .clr_req(clr_req),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .init_busy(init_busy), .dbg_stall(dbg_stall), .wb_conflict(wb_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it, clear of the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {init_busy, dbg_ready, rf_we, rf_rd, rf_wdata}
  function automatic logic [63:0] pack(input logic ib, input logic rdy, input logic we,
                                       input logic [4:0] rd, input logic [31:0] d);
    return {25'd0, ib, rdy, we, rd, d};
  endfunction

  function automatic logic [63:0] obs_now();
    return pack(init_busy, dbg_ready, rf_we, rf_rd, rf_wdata);
  endfunction

  initial begin
    rst = 1'b0; wb_we = 0; wb_rd = 0; wb_data = 0;
    dbg_valid = 0; dbg_rd = 0; dbg_data = 0; clr_req = 0;
    #12;
    check("reset_outputs", obs_now(), pack(0, 0, 0, 0, 0));
    check("reset_regs", {62'd0, dbg_stall, wb_conflict}, 64'd0);

    tick();
    rst = 1'b1;
    #1;
    for (int i = 1; i <= 31; i++) begin
      check($sformatf("clear_%0d", i), obs_now(), pack(1, 0, 1, 5'(i), 0));
      tick();
    end
    check("run_idle", obs_now(), pack(0, 1, 0, 0, 0));

    // WB beats a simultaneous debug request, debug goes through next cycle.
    wb_we = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    dbg_valid = 1; dbg_rd = 7; dbg_data = 32'h0000_0077;
    #1;
    check("wb_priority", obs_now(), pack(0, 0, 1, 5, 32'hDEADBEEF));
    tick();
    wb_we = 0;
    #1;
    check("dbg_after_wb", obs_now(), pack(0, 1, 1, 7, 32'h77));
    tick();
    dbg_valid = 0;
    #1;
    check("no_stall_after_hs", {63'd0, dbg_stall}, 64'd0);

    // WB to x0 does not block debug.
    wb_we = 1; wb_rd = 0; wb_data = 32'hFFFF_FFFF;
    dbg_valid = 1; dbg_rd = 3; dbg_data = 32'h12;
    #1;
    check("wb_x0_dbg", obs_now(), pack(0, 1, 1, 3, 32'h12));
    tick();

    // Debug write to x0 is accepted but writes nothing.
    wb_we = 0; dbg_rd = 0; dbg_data = 32'h55;
    #1;
    check("dbg_x0", obs_now(), pack(0, 1, 0, 0, 0));
    tick();
    dbg_valid = 0;

    // Starvation: stall appears after the 8th blocked cycle.
    wb_we = 1; wb_rd = 9; wb_data = 32'h99;
    dbg_valid = 1; dbg_rd = 11; dbg_data = 32'hAB;
    #1;
    check("starve_0", {63'd0, dbg_stall}, 64'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("starve_%0d", k), {63'd0, dbg_stall}, {63'd0, k == 8});
    end
    wb_we = 0;
    #1;
    check("starve_hs", obs_now(), pack(0, 1, 1, 11, 32'hAB));
    check("stall_held_hs", {63'd0, dbg_stall}, 64'd1);
    tick();
    dbg_valid = 0;
    check("stall_cleared", {63'd0, dbg_stall}, 64'd0);

    // Saturated wait then withdrawal.
    wb_we = 1; dbg_valid = 1;
    for (int k = 1; k <= 10; k++) tick();
    check("stall_saturated", {63'd0, dbg_stall}, 64'd1);
    dbg_valid = 0;
    tick();
    check("withdraw_clears", {63'd0, dbg_stall}, 64'd0);

    // Re-clear: WB in the clr_req cycle is still written.
    wb_rd = 4; wb_data = 32'h44; clr_req = 1;
    #1;
    check("clr_wb_written", obs_now(), pack(0, 0, 1, 4, 32'h44));
    tick();
    clr_req = 0; wb_we = 0;
    #1;
    for (int i = 1; i <= 31; i++) begin
      wb_we   = (i == 3);
      wb_rd   = 6;
      wb_data = 32'h66;
      clr_req = (i == 5);
      #1;
      check($sformatf("reclear_%0d", i), obs_now(), pack(1, 0, 1, 5'(i), 0));
      if (i == 4 || i == 5)
        check($sformatf("conflict_%0d", i), {63'd0, wb_conflict}, {63'd0, i == 4});
      tick();
    end
    wb_we = 0; clr_req = 0;
    #1;
    check("reclear_done", obs_now(), pack(0, 1, 0, 0, 0));

    // Reset asserted mid-clear at clr_idx = 10.
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int i = 1; i < 10; i++) tick();
    #1;
    check("midclear_idx10", obs_now(), pack(1, 0, 1, 10, 0));
    rst = 1'b0;
    #1;
    check("async_reset", obs_now(), pack(0, 0, 0, 0, 0));
    tick();
    rst = 1'b1;
    #1;
    check("restart_1", obs_now(), pack(1, 0, 1, 1, 0));
    tick();
    check("restart_2", obs_now(), pack(1, 0, 1, 2, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Owns the single write port of the 32x32 integer register file in the 5-stage RV32I pipeline.
- Runs a sequenced post-reset clear (one register per cycle), then shares the write port between writeback (WB) and a debug/loader requester.
- WB has priority over debug. A starvation counter stalls the pipeline so that debug writes always complete.

Parameters:
- XLEN, 32, data width
- NREG, 32, register count; index width is log2(NREG) = 5
- MAX_WAIT, 8, cycles a pending debug request may be blocked before dbg_stall asserts (>=1)

Ports:
- clk  in  1  clock; FSM/counters update on posedge
- rst  in  1  asynchronous, active-low reset
- wb_we  in  1  WB write enable (RegWriteW)
- wb_rd  in  5  WB destination (RdW)
- wb_data  in  XLEN  WB result (ResultW)
- dbg_valid  in  1  debug write request
- dbg_rd  in  5  debug destination
- dbg_data  in  XLEN  debug data
- dbg_ready  out  1  debug request accepted this cycle
- clr_req  in  1  single-cycle pulse requesting a full re-clear
- rf_we  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- init_busy  out  1  clear sequence running; pipeline must hold
- dbg_stall  out  1  request pipeline freeze to drain WB for debug
- wb_conflict  out  1  one-cycle pulse: a WB write was discarded during CLEAR

Behaviour:
- States: CLEAR, RUN. Registered: state, clr_idx[4:0], wait_cnt, dbg_stall, wb_conflict.
- All rf_* and dbg_ready outputs are combinational from the registered state and the current inputs.
- Zero latency on the WB path, so a WB write reaches the file in the same cycle it is presented.

Reset (rst=0, async):
- state=CLEAR, clr_idx=1, wait_cnt=0, dbg_stall=0, wb_conflict=0.
- While rst=0, all outputs are held 0 (rf_we=0, dbg_ready=0, init_busy=0).

CLEAR:
- init_busy=1, rf_we=1, rf_rd=clr_idx, rf_wdata=0; clr_idx increments each cycle.
- When clr_idx=NREG-1 is written, go to RUN next cycle.
- CLEAR therefore takes NREG-1 = 31 cycles; x0 is never written.
- dbg_ready=0 throughout CLEAR.
- wb_we=1 during CLEAR: the write is discarded and wb_conflict pulses the next cycle.
- clr_req during CLEAR is ignored.

RUN, priority order:
1. clr_req=1: go to CLEAR, reset clr_idx=1 and wait_cnt=0, and deassert dbg_stall. A WB write in the same cycle is still performed.
2. Effective WB write (wb_we=1 and wb_rd!=0): rf_we=1, rf_rd=wb_rd, rf_wdata=wb_data, dbg_ready=0.
3. Otherwise dbg_ready=1. If dbg_valid=1 as well:
   - rf_we=(dbg_rd!=0), rf_rd=dbg_rd, rf_wdata=dbg_data.
   - The request is consumed: wait_cnt clears and dbg_stall deasserts next cycle.
   - A debug write to x0 is accepted but writes nothing.

Common rules:
- x0 rule: rf_we is never 1 with rf_rd=0. A WB write to x0 does not block debug.
- Starvation:
  - wait_cnt increments (saturating) each RUN cycle with dbg_valid=1 and dbg_ready=0.
  - When wait_cnt reaches MAX_WAIT, dbg_stall is set (registered).
  - It stays set until the debug transfer occurs, clr_req arrives, or reset.
- Debug requester rule: dbg_valid, dbg_rd and dbg_data must stay stable until the handshake (dbg_valid=1 and dbg_ready=1).
- Withdrawal: if dbg_valid drops without a handshake, wait_cnt clears and dbg_stall clears next cycle.
- rf_* outputs are don't-care when rf_we=0; drive 0.

Test Plan:
- Release reset -> exactly 31 cycles of rf_we=1, rf_rd=1..31 in order, rf_wdata=0, init_busy=1; then init_busy=0 and rf_we=0 when idle.
- RUN: wb_we=1, wb_rd=5, wb_data=0xDEADBEEF plus dbg_valid=1, dbg_rd=7 in the same cycle -> rf writes x5=0xDEADBEEF, dbg_ready=0. Next cycle with wb_we=0 -> dbg_ready=1 and x7 is written.
- wb_we=1, wb_rd=0 with dbg_valid=1, dbg_rd=3, dbg_data=0x12 -> rf_we=1, rf_rd=3, rf_wdata=0x12, dbg_ready=1.
- wb_we held 1 (rd=9) with dbg_valid held 1 and MAX_WAIT=8 -> dbg_stall=1 after the 8th blocked cycle. Drop wb_we -> handshake that cycle, dbg_stall=0 next cycle.
- clr_req pulse in RUN with wb_we=1, rd=4 -> x4 written that cycle, then a 31-cycle CLEAR. wb_we during CLEAR -> no write, wb_conflict pulses once.
- Assert rst low mid-CLEAR (clr_idx=10) -> outputs go 0 immediately. On release, CLEAR restarts at rf_rd=1.
